// File: rtl/des_pkg.sv
// Shared DES datapath types: nibble and word widths used by the selector,
// S-box and packer blocks.
package des_pkg;
    localparam int NIB_W       = 4;
    localparam int NUM_NIBBLES = 8;
    localparam int WORD_W      = NIB_W * NUM_NIBBLES;

    typedef logic [NIB_W-1:0]  nibble_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/nibble_slot_writer.sv
// Combinational slot insert: writes one nibble into its slot of the accumulator.
// Fill order is LSB-first unless PACKER_MSB_FIRST_EN is defined.
module nibble_slot_writer
    import des_pkg::*;
(
    input  logic [WORD_W-1:0] acc_in,
    input  logic [2:0]        slot,
    input  logic [NIB_W-1:0]  nib,
    output logic [WORD_W-1:0] acc_out
);
    logic [2:0] pos;

    always_comb begin
`ifdef PACKER_MSB_FIRST_EN
        // arrival k lands at nibble position 7-k, i.e. bits [31-4k:28-4k]
        pos = ~slot;
`else
        pos = slot;
`endif
        acc_out = acc_in;
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (pos == 3'(i)) begin
                acc_out[i*NIB_W +: NIB_W] = nib;
            end
        end
    end
endmodule

// File: rtl/sbox_nibble_packer.sv
// Double-buffered packer: eight nibbles per handshake into a 32-bit word.
// Optional macro PACKER_MSB_FIRST_EN reverses the fill order (see nibble_slot_writer).
module sbox_nibble_packer #(
    parameter int NUM_NIBBLES = 8,
    parameter int NIB_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [3:0]  nibble_in,
    input  logic        nibble_valid,
    output logic        nibble_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [2:0]  slot_idx
);
    if (NUM_NIBBLES != 8 || NIB_W != 4) begin : g_width_check
        $error("sbox_nibble_packer supports only 8 nibbles of 4 bits");
    end

    logic [2:0]  slot_q, slot_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] word_q, word_d;
    logic        wvld_q, wvld_d;
    logic [31:0] acc_upd;
    logic        accept;

    nibble_slot_writer u_writer (
        .acc_in  (acc_q),
        .slot    (slot_q),
        .nib     (nibble_in),
        .acc_out (acc_upd)
    );

    // Only the completing nibble stalls, and only while the held word is not consumed.
    assign nibble_ready = !((slot_q == 3'd7) && wvld_q && !word_ready);
    assign accept       = nibble_valid && nibble_ready;

    always_comb begin
        slot_d = slot_q;
        acc_d  = acc_q;
        word_d = word_q;
        wvld_d = wvld_q;
        if (clear) begin
            slot_d = 3'd0;
            acc_d  = '0;
            word_d = '0;
            wvld_d = 1'b0;
        end else begin
            if (wvld_q && word_ready) begin
                wvld_d = 1'b0;
            end
            if (accept) begin
                if (slot_q == 3'd7) begin
                    // completion overrides the consume so a reload keeps word_valid high
                    word_d = acc_upd;
                    wvld_d = 1'b1;
                    acc_d  = '0;
                    slot_d = 3'd0;
                end else begin
                    acc_d  = acc_upd;
                    slot_d = slot_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 3'd0;
            acc_q  <= '0;
            word_q <= '0;
            wvld_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            wvld_q <= wvld_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = wvld_q;
    assign slot_idx   = slot_q;
endmodule

// File: tb/tb_sbox_nibble_packer.sv
// Directed bench for sbox_nibble_packer; expected words follow the fill order
// selected by PACKER_MSB_FIRST_EN.
module tb_sbox_nibble_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  nibble_in = 4'h0;
    logic        nibble_valid = 1'b0;
    logic        nibble_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [2:0]  slot_idx;

    int checks = 0;
    int errors = 0;

`ifdef PACKER_MSB_FIRST_EN
    localparam logic [31:0] EXP_W1   = 32'h12345678;
    localparam logic [31:0] EXP_W2   = 32'hFEDCBA98;
    localparam logic [31:0] EXP_PI   = 32'h31415926;
`else
    localparam logic [31:0] EXP_W1   = 32'h87654321;
    localparam logic [31:0] EXP_W2   = 32'h89ABCDEF;
    localparam logic [31:0] EXP_PI   = 32'h62951413;
`endif
    localparam logic [31:0] EXP_AAAA = 32'hAAAAAAAA;

    logic [3:0] pi_nibs [8] = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};

    sbox_nibble_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .nibble_in    (nibble_in),
        .nibble_valid (nibble_valid),
        .nibble_ready (nibble_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .slot_idx     (slot_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] n);
        nibble_valid = 1'b1;
        nibble_in    = n;
        step();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_word_out", word_out, 32'h0);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_slot", {29'd0, slot_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_nibble_ready", {31'd0, nibble_ready}, 32'd1);

        // Word 1, back to back, word_ready high
        word_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            offer(4'(i));
            chk("w1_slot", {29'd0, slot_idx}, 32'(i));
        end
        chk("w1_not_valid_early", {31'd0, word_valid}, 32'd0);
        offer(4'h8);
        chk("w1_valid", {31'd0, word_valid}, 32'd1);
        chk("w1_word", word_out, EXP_W1);
        chk("w1_slot_wrap", {29'd0, slot_idx}, 32'd0);

        // Word 2 streamed immediately; ready must never drop
        for (int i = 0; i < 8; i++) begin
            nibble_valid = 1'b1;
            nibble_in    = 4'(15 - i);
            #1;
            chk("w2_nibble_ready", {31'd0, nibble_ready}, 32'd1);
            step();
            if (i == 0) chk("w2_w1_consumed", {31'd0, word_valid}, 32'd0);
        end
        chk("w2_valid", {31'd0, word_valid}, 32'd1);
        chk("w2_word", word_out, EXP_W2);

        // Backpressure: word 2 held, slots 0..6 still fill
        word_ready = 1'b0;
        for (int i = 1; i <= 7; i++) offer(4'(i));
        chk("bp_slot7", {29'd0, slot_idx}, 32'd7);
        chk("bp_held_word", word_out, EXP_W2);
        chk("bp_held_valid", {31'd0, word_valid}, 32'd1);
        nibble_in = 4'h8;
        #1;
        chk("bp_ready_low", {31'd0, nibble_ready}, 32'd0);
        step();
        chk("bp_stalled_slot", {29'd0, slot_idx}, 32'd7);
        chk("bp_still_held", word_out, EXP_W2);
        word_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {31'd0, nibble_ready}, 32'd1);
        step();
        chk("bp_reload_valid", {31'd0, word_valid}, 32'd1);
        chk("bp_reload_word", word_out, EXP_W1);
        chk("bp_reload_slot", {29'd0, slot_idx}, 32'd0);
        nibble_valid = 1'b0;
        step();
        chk("bp_consumed", {31'd0, word_valid}, 32'd0);

        // Clear mid-word drops the presented nibble
        offer(4'h5);
        offer(4'h6);
        offer(4'h7);
        chk("clr_pre_slot", {29'd0, slot_idx}, 32'd3);
        clear = 1'b1;
        offer(4'h9);
        clear = 1'b0;
        chk("clr_slot", {29'd0, slot_idx}, 32'd0);
        chk("clr_valid", {31'd0, word_valid}, 32'd0);
        chk("clr_word", word_out, 32'h0);
        for (int i = 0; i < 8; i++) offer(4'hA);
        chk("clr_after_word", word_out, EXP_AAAA);
        chk("clr_after_valid", {31'd0, word_valid}, 32'd1);

        // Asynchronous reset mid-word
        offer(4'hC);
        offer(4'hD);
        nibble_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", word_out, 32'h0);
        chk("arst_valid", {31'd0, word_valid}, 32'd0);
        chk("arst_slot", {29'd0, slot_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) offer(pi_nibs[i]);
        chk("arst_after_word", word_out, EXP_PI);
        chk("arst_after_valid", {31'd0, word_valid}, 32'd1);
        nibble_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
